// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request/write-data port among NUM_CLIENTS cache clients.
// Default arbitration is round-robin; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mem_arbiter #(
    parameter int NUM_CLIENTS  = 2,
    parameter int ADDR_BITS    = 28,
    parameter int DATA_BITS    = 128,
    parameter int TAG_BITS     = 5,
    parameter int WRITE_BEATS  = 4,
    localparam int ID_BITS     = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1,
    localparam int CTAG_BITS   = TAG_BITS - ID_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CLIENTS-1:0]          cli_req_valid,
    output logic [NUM_CLIENTS-1:0]          cli_req_ready,
    input  logic [NUM_CLIENTS-1:0]          cli_req_rw,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cli_req_addr,
    input  logic [NUM_CLIENTS*CTAG_BITS-1:0] cli_req_tag,
    input  logic [NUM_CLIENTS-1:0]          cli_data_valid,
    output logic [NUM_CLIENTS-1:0]          cli_data_ready,
    input  logic [NUM_CLIENTS*DATA_BITS-1:0] cli_data_bits,
    input  logic [NUM_CLIENTS*DATA_BITS/8-1:0] cli_data_mask,
    output logic [NUM_CLIENTS-1:0]          cli_resp_valid,
    output logic [CTAG_BITS-1:0]            cli_resp_tag,
    output logic [DATA_BITS-1:0]            cli_resp_data,
    output logic                            mem_req_valid,
    output logic                            mem_req_rw,
    output logic [ADDR_BITS-1:0]            mem_req_addr,
    output logic [TAG_BITS-1:0]             mem_req_tag,
    input  logic                            mem_req_ready,
    output logic                            mem_req_data_valid,
    input  logic                            mem_req_data_ready,
    output logic [DATA_BITS-1:0]            mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]          mem_req_data_mask,
    input  logic                            mem_resp_valid,
    input  logic [TAG_BITS-1:0]             mem_resp_tag,
    input  logic [DATA_BITS-1:0]            mem_resp_data
);

    localparam int BEAT_BITS = (WRITE_BEATS > 1) ? $clog2(WRITE_BEATS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WDATA = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [ID_BITS-1:0]   grant_q, grant_d;
    logic [BEAT_BITS-1:0] beat_q, beat_d;
    logic [ID_BITS-1:0]   win_idx;
    logic                 win_found;
    logic                 req_hs;
    logic                 beat_hs;

    assign req_hs  = (state_q == REQ) && mem_req_ready;
    assign beat_hs = (state_q == WDATA) && cli_data_valid[grant_q] && mem_req_data_ready;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (cli_req_valid[i]) begin
                win_found = 1'b1;
                win_idx   = ID_BITS'(i);
            end
        end
    end
`else
    logic [ID_BITS-1:0] ptr_q, ptr_d;
    int                 cand;

    // Scan from farthest to nearest so the first valid client at/after the pointer wins last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
            if (cli_req_valid[cand[ID_BITS-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_BITS-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (req_hs) ptr_d = (int'(grant_q) == NUM_CLIENTS - 1) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_hs) begin
                    state_d = cli_req_rw[grant_q] ? WDATA : IDLE;
                    beat_d  = '0;
                end
            end
            WDATA: begin
                if (beat_hs) begin
                    if (beat_q == BEAT_BITS'(WRITE_BEATS - 1)) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

    // Handshake outputs are decoded from registered state only, so reset clears them at once.
    always_comb begin
        mem_req_valid      = (state_q == REQ);
        mem_req_data_valid = (state_q == WDATA) && cli_data_valid[grant_q];
        cli_req_ready      = '0;
        cli_data_ready     = '0;
        if (state_q == REQ)   cli_req_ready[grant_q]  = mem_req_ready;
        if (state_q == WDATA) cli_data_ready[grant_q] = mem_req_data_ready;
    end

    assign mem_req_rw        = cli_req_rw[grant_q];
    assign mem_req_addr      = cli_req_addr[int'(grant_q)*ADDR_BITS +: ADDR_BITS];
    assign mem_req_tag       = {grant_q, cli_req_tag[int'(grant_q)*CTAG_BITS +: CTAG_BITS]};
    assign mem_req_data_bits = cli_data_bits[int'(grant_q)*DATA_BITS +: DATA_BITS];
    assign mem_req_data_mask = cli_data_mask[int'(grant_q)*(DATA_BITS/8) +: DATA_BITS/8];

    // Responses bypass the arbiter entirely; unmapped client IDs are dropped.
    always_comb begin
        cli_resp_valid = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cli_resp_valid[i] = mem_resp_valid &&
                                (mem_resp_tag[TAG_BITS-1 -: ID_BITS] == ID_BITS'(i));
        end
    end

    assign cli_resp_tag  = mem_resp_tag[CTAG_BITS-1:0];
    assign cli_resp_data = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-client and a 3-client instance, response routing table plus
// scoreboarded request/beat sequences (round-robin, locked write burst, reset mid-burst).
`timescale 1ns/1ps
module tb_mem_arbiter;

    typedef struct {
        bit         sel3;
        logic       rv;
        logic [4:0] rt;
        logic [2:0] ev;
        logic [3:0] et;
    } vec_t;

    logic clk;
    logic reset;

    logic [1:0]   cli_req_valid, cli_req_ready, cli_req_rw;
    logic [55:0]  cli_req_addr;
    logic [7:0]   cli_req_tag;
    logic [1:0]   cli_data_valid, cli_data_ready, cli_resp_valid;
    logic [255:0] cli_data_bits;
    logic [31:0]  cli_data_mask;
    logic [3:0]   cli_resp_tag;
    logic [127:0] cli_resp_data;
    logic         mem_req_valid, mem_req_rw, mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic [4:0]   mem_req_tag;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [4:0]   mem_resp_tag;
    logic [127:0] mem_resp_data;

    logic [2:0]  t3_cli_req_valid, t3_cli_req_ready, t3_cli_req_rw;
    logic [83:0] t3_cli_req_addr;
    logic [8:0]  t3_cli_req_tag;
    logic [2:0]  t3_cli_data_valid, t3_cli_data_ready, t3_cli_resp_valid;
    logic [95:0] t3_cli_data_bits;
    logic [11:0] t3_cli_data_mask;
    logic [2:0]  t3_cli_resp_tag;
    logic [31:0] t3_cli_resp_data;
    logic        t3_mem_req_valid, t3_mem_req_rw, t3_mem_req_ready;
    logic [27:0] t3_mem_req_addr;
    logic [4:0]  t3_mem_req_tag;
    logic        t3_mem_req_data_valid, t3_mem_req_data_ready;
    logic [31:0] t3_mem_req_data_bits;
    logic [3:0]  t3_mem_req_data_mask;
    logic        t3_mem_resp_valid;
    logic [4:0]  t3_mem_resp_tag;
    logic [31:0] t3_mem_resp_data;

    int n_chk  = 0;
    int n_fail = 0;
    logic [33:0]  exp_q[$];
    logic [143:0] beat_q[$];
    logic [33:0]  exp3_q[$];
    bit           hs_req, hs_beat;
    logic         hs_id;

    mem_arbiter u_dut2 (
        .clk(clk), .reset(reset),
        .cli_req_valid(cli_req_valid), .cli_req_ready(cli_req_ready), .cli_req_rw(cli_req_rw),
        .cli_req_addr(cli_req_addr), .cli_req_tag(cli_req_tag),
        .cli_data_valid(cli_data_valid), .cli_data_ready(cli_data_ready),
        .cli_data_bits(cli_data_bits), .cli_data_mask(cli_data_mask),
        .cli_resp_valid(cli_resp_valid), .cli_resp_tag(cli_resp_tag), .cli_resp_data(cli_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
    );

    mem_arbiter #(.NUM_CLIENTS(3), .ADDR_BITS(28), .DATA_BITS(32), .TAG_BITS(5), .WRITE_BEATS(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .cli_req_valid(t3_cli_req_valid), .cli_req_ready(t3_cli_req_ready), .cli_req_rw(t3_cli_req_rw),
        .cli_req_addr(t3_cli_req_addr), .cli_req_tag(t3_cli_req_tag),
        .cli_data_valid(t3_cli_data_valid), .cli_data_ready(t3_cli_data_ready),
        .cli_data_bits(t3_cli_data_bits), .cli_data_mask(t3_cli_data_mask),
        .cli_resp_valid(t3_cli_resp_valid), .cli_resp_tag(t3_cli_resp_tag), .cli_resp_data(t3_cli_resp_data),
        .mem_req_valid(t3_mem_req_valid), .mem_req_rw(t3_mem_req_rw), .mem_req_addr(t3_mem_req_addr),
        .mem_req_tag(t3_mem_req_tag), .mem_req_ready(t3_mem_req_ready),
        .mem_req_data_valid(t3_mem_req_data_valid), .mem_req_data_ready(t3_mem_req_data_ready),
        .mem_req_data_bits(t3_mem_req_data_bits), .mem_req_data_mask(t3_mem_req_data_mask),
        .mem_resp_valid(t3_mem_resp_valid), .mem_resp_tag(t3_mem_resp_tag), .mem_resp_data(t3_mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none at %0t", name, $time);
    endtask

    function automatic logic [143:0] beat_val(input int k);
        return {{4{32'hCAFE_0000 | 32'(k)}}, 16'h0F0F ^ 16'(k)};
    endfunction

    task automatic drive_beat(input int k);
        logic [143:0] v;
        v = beat_val(k);
        cli_data_bits[128 +: 128] = v[143:16];
        cli_data_mask[16 +: 16]   = v[15:0];
    endtask

    // Sampled just before the rising edge: whatever handshakes are visible here complete on that edge.
    task automatic mon();
        logic [33:0]  e;
        logic [143:0] b;
        hs_req  = 1'b0;
        hs_beat = 1'b0;
        if (mem_req_valid && mem_req_ready) begin
            hs_req = 1'b1;
            hs_id  = mem_req_tag[4];
            if (exp_q.size() == 0) flag("unexpected_mem_req");
            else begin
                e = exp_q.pop_front();
                check("mem_req", 160'({mem_req_rw, mem_req_addr, mem_req_tag}), 160'(e));
            end
        end
        if (mem_req_valid && beat_q.size() != 0)
            check("grant_locked", 160'(mem_req_tag[4]), 160'(1));
        if (mem_req_data_valid && mem_req_data_ready) begin
            hs_beat = 1'b1;
            if (beat_q.size() == 0) flag("unexpected_beat");
            else begin
                b = beat_q.pop_front();
                check("beat", 160'({mem_req_data_bits, mem_req_data_mask}), 160'(b));
            end
        end
        if (t3_mem_req_valid && t3_mem_req_ready) begin
            if (exp3_q.size() == 0) flag("unexpected_mem_req3");
            else begin
                e = exp3_q.pop_front();
                check("grant_order3", 160'({t3_mem_req_rw, t3_mem_req_addr, t3_mem_req_tag}), 160'(e));
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl [8];
        int   budget;
        int   bidx;
        bit   resp_done;

        tbl[0] = '{1'b0, 1'b1, 5'b1_0011, 3'b010, 4'h3};
        tbl[1] = '{1'b0, 1'b1, 5'b0_1010, 3'b001, 4'hA};
        tbl[2] = '{1'b0, 1'b0, 5'b1_0011, 3'b000, 4'h3};
        tbl[3] = '{1'b0, 1'b1, 5'b1_1111, 3'b010, 4'hF};
        tbl[4] = '{1'b1, 1'b1, 5'b11_101, 3'b000, 4'h5};
        tbl[5] = '{1'b1, 1'b1, 5'b10_001, 3'b100, 4'h1};
        tbl[6] = '{1'b1, 1'b1, 5'b01_110, 3'b010, 4'h6};
        tbl[7] = '{1'b1, 1'b1, 5'b00_000, 3'b001, 4'h0};

        reset              = 1'b1;
        cli_req_valid      = 2'b11;
        cli_req_rw         = 2'b00;
        cli_req_addr       = {28'h200, 28'h100};
        cli_req_tag        = {4'hA, 4'h5};
        cli_data_valid     = 2'b00;
        cli_data_bits      = {128'h0, {4{32'hDEAD_BEEF}}};
        cli_data_mask      = {16'h0, 16'hFFFF};
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_tag       = '0;
        mem_resp_data      = '0;
        t3_cli_req_valid   = 3'b000;
        t3_cli_req_rw      = 3'b000;
        t3_cli_req_addr    = {28'h300, 28'h200, 28'h100};
        t3_cli_req_tag     = {3'h3, 3'h2, 3'h1};
        t3_cli_data_valid  = 3'b000;
        t3_cli_data_bits   = '0;
        t3_cli_data_mask   = '0;
        t3_mem_req_ready   = 1'b1;
        t3_mem_req_data_ready = 1'b0;
        t3_mem_resp_valid  = 1'b0;
        t3_mem_resp_tag    = '0;
        t3_mem_resp_data   = '0;

        // Reset holds every handshake output low even with requests pending.
        #1;
        check("rst_mem_req_valid", 160'(mem_req_valid), 160'(0));
        check("rst_mem_req_data_valid", 160'(mem_req_data_valid), 160'(0));
        check("rst_cli_req_ready", 160'(cli_req_ready), 160'(0));
        check("rst_cli_data_ready", 160'(cli_data_ready), 160'(0));
        check("rst_t3_cli_req_ready", 160'(t3_cli_req_ready), 160'(0));
        check("rst_t3_data", 160'({t3_mem_req_data_valid, t3_cli_data_ready}), 160'(0));
        @(posedge clk);
        #1;
        cyc();
        check("rst_held_mem_req_valid", 160'(mem_req_valid), 160'(0));
        cli_req_valid = 2'b00;
        reset         = 1'b0;
        cyc();

        // Response routing table (combinational).
        for (int i = 0; i < 8; i++) begin
            mem_resp_valid    = 1'b0;
            t3_mem_resp_valid = 1'b0;
            if (!tbl[i].sel3) begin
                mem_resp_valid = tbl[i].rv;
                mem_resp_tag   = tbl[i].rt;
                mem_resp_data  = {4{32'h1234_0000 | 32'(i)}};
            end else begin
                t3_mem_resp_valid = tbl[i].rv;
                t3_mem_resp_tag   = tbl[i].rt;
                t3_mem_resp_data  = 32'h5678_0000 | 32'(i);
            end
            #1;
            if (!tbl[i].sel3) begin
                check("resp_valid", 160'(cli_resp_valid), 160'(tbl[i].ev));
                check("resp_tag", 160'(cli_resp_tag), 160'(tbl[i].et));
                check("resp_data", 160'(cli_resp_data), 160'({4{32'h1234_0000 | 32'(i)}}));
            end else begin
                check("resp3_valid", 160'(t3_cli_resp_valid), 160'(tbl[i].ev));
                check("resp3_tag", 160'(t3_cli_resp_tag), 160'(tbl[i].et));
                check("resp3_data", 160'(t3_cli_resp_data), 160'(32'h5678_0000 | 32'(i)));
            end
        end
        mem_resp_valid    = 1'b0;
        t3_mem_resp_valid = 1'b0;
        cyc();

        // Two clients reading back-to-back.
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 28'h100, 5'h05});
`else
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 28'h100, 5'h05});
            exp_q.push_back({1'b0, 28'h200, 5'h1A});
        end
`endif
        cli_req_valid = 2'b11;
        budget = 30;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc();
            budget--;
        end
        if (exp_q.size() != 0) flag("timeout_reads");
        exp_q.delete();
        cli_req_valid = 2'b00;
        cyc();

        // Client 1 write burst with throttled data ready; client 0 waits throughout.
        cli_req_rw              = 2'b10;
        cli_req_addr[28 +: 28]  = 28'h40;
        cli_req_tag[4 +: 4]     = 4'h3;
        cli_data_valid          = 2'b11;
        bidx = 0;
        drive_beat(0);
        exp_q.push_back({1'b1, 28'h40, 5'h13});
        exp_q.push_back({1'b0, 28'h100, 5'h05});
        for (int k = 0; k < 4; k++) beat_q.push_back(beat_val(k));
        cli_req_valid = 2'b10;
        cyc();
        cli_req_valid      = 2'b11;
        mem_req_data_ready = 1'b0;
        resp_done = 1'b0;
        budget    = 60;
        while ((exp_q.size() != 0 || beat_q.size() != 0) && budget > 0) begin
            cyc();
            budget--;
            if (hs_req && hs_id)  cli_req_valid[1] = 1'b0;
            if (hs_req && !hs_id) cli_req_valid[0] = 1'b0;
            if (hs_beat) begin
                bidx++;
                drive_beat(bidx);
            end
            mem_req_data_ready = ~mem_req_data_ready;
            if (bidx == 1 && !resp_done) begin
                mem_resp_valid = 1'b1;
                mem_resp_tag   = 5'h0C;
                #1;
                check("resp_during_wdata_valid", 160'(cli_resp_valid), 160'(2'b01));
                check("resp_during_wdata_tag", 160'(cli_resp_tag), 160'(4'hC));
                mem_resp_valid = 1'b0;
                resp_done = 1'b1;
            end
        end
        if (exp_q.size() != 0 || beat_q.size() != 0) flag("timeout_write");
        exp_q.delete();
        beat_q.delete();
        cli_req_valid = 2'b00;
        cyc();

        // Reset lands after the second beat of a write.
        cli_req_addr[28 +: 28] = 28'h80;
        cli_req_tag[4 +: 4]    = 4'h7;
        bidx = 0;
        drive_beat(0);
        exp_q.push_back({1'b1, 28'h80, 5'h17});
        beat_q.push_back(beat_val(0));
        beat_q.push_back(beat_val(1));
        mem_req_data_ready = 1'b1;
        cli_req_valid      = 2'b10;
        budget = 30;
        while ((exp_q.size() != 0 || beat_q.size() != 0) && budget > 0) begin
            cyc();
            budget--;
            if (hs_req) cli_req_valid[1] = 1'b0;
            if (hs_beat) begin
                bidx++;
                drive_beat(bidx);
            end
        end
        if (exp_q.size() != 0 || beat_q.size() != 0) flag("timeout_write2");
        exp_q.delete();
        beat_q.delete();
        reset = 1'b1;
        #1;
        check("midrst_mem_req_data_valid", 160'(mem_req_data_valid), 160'(0));
        check("midrst_cli_data_ready", 160'(cli_data_ready), 160'(0));
        check("midrst_mem_req_valid", 160'(mem_req_valid), 160'(0));
        check("midrst_cli_req_ready", 160'(cli_req_ready), 160'(0));
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            check("no_residual_beat", 160'({mem_req_data_valid, cli_data_ready}), 160'(0));
        end
        exp_q.push_back({1'b0, 28'h100, 5'h05});
        cli_req_valid = 2'b01;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc();
            budget--;
        end
        if (exp_q.size() != 0) flag("timeout_post_reset_read");
        exp_q.delete();
        cli_req_valid = 2'b00;
        cyc();

        // Three clients all requesting.
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) exp3_q.push_back({1'b0, 28'h100, 5'h01});
`else
        exp3_q.push_back({1'b0, 28'h100, 5'h01});
        exp3_q.push_back({1'b0, 28'h200, 5'h0A});
        exp3_q.push_back({1'b0, 28'h300, 5'h13});
        exp3_q.push_back({1'b0, 28'h100, 5'h01});
`endif
        t3_cli_req_valid = 3'b111;
        budget = 30;
        while (exp3_q.size() != 0 && budget > 0) begin
            cyc();
            budget--;
        end
        if (exp3_q.size() != 0) flag("timeout_three_clients");
        exp3_q.delete();
        t3_cli_req_valid = 3'b000;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
